// File: rtl/mem_pkg.sv
// Shared encodings, address map constants and FSM state type for the memory responder.
package mem_pkg;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;
  localparam logic [1:0] MILL   = 2'b11;

  localparam logic [8:0] LED_ADDR = 9'h100;
  localparam logic [8:0] SW_ADDR  = 9'h140;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  function automatic logic is_access(input logic [1:0] cmd);
    return (cmd == MREAD) || (cmd == MWRITE);
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU memory bus: command, address and write data from the CPU; read data and ready pulse back.
interface mem_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
);

  logic [1:0]        mem_cmd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              mem_ready;

  modport master (
    output mem_cmd, mem_addr, write_data,
    input  read_data, mem_ready
  );

  modport slave (
    input  mem_cmd, mem_addr, write_data,
    output read_data, mem_ready
  );

endinterface

// File: rtl/mem_responder_ram_array.sv
// Single-port data RAM: synchronous write, asynchronous read, contents never reset.
module ram_array #(
  parameter int DATA_W    = 16,
  parameter int RAM_DEPTH = 256,
  localparam int AW       = $clog2(RAM_DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: RAM, LED and switch registers behind a wait-stated single-request bus.
// Optional build macro MEM_ERR_EN adds a sticky access-error flag on err.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 9,
  parameter int RAM_DEPTH   = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus,
  input  logic [7:0]      sw,
  output logic [7:0]      led,
  output logic            err
);

  localparam int               RAM_AW    = $clog2(RAM_DEPTH);
  localparam logic [3:0]       WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [ADDR_W:0]  RAM_TOP   = (ADDR_W + 1)'(RAM_DEPTH);

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              accept;
  logic              enter_done;

  logic [1:0]        cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [1:0]        cmd_eff;
  logic [ADDR_W-1:0] addr_eff;
  logic [DATA_W-1:0] wdata_eff;

  logic              hit_ram, hit_led, hit_sw;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] rd_mux;

  logic [7:0]        sw_meta, sw_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (is_access(bus.mem_cmd)) begin
          accept    = 1'b1;
          cnt_nxt   = WAIT_LOAD;
          state_nxt = (WAIT_STATES > 0) ? WAIT : DONE;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = DONE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      cmd_q   <= bus.mem_cmd;
      addr_q  <= bus.mem_addr;
      wdata_q <= bus.write_data;
    end
  end

  // With zero wait states the commit edge is also the accept edge, so use the live request in IDLE.
  assign cmd_eff    = (state == IDLE) ? bus.mem_cmd    : cmd_q;
  assign addr_eff   = (state == IDLE) ? bus.mem_addr   : addr_q;
  assign wdata_eff  = (state == IDLE) ? bus.write_data : wdata_q;
  assign enter_done = (state_nxt == DONE) && (state != DONE);

  assign hit_ram = ({1'b0, addr_eff} < RAM_TOP);
  assign hit_led = (addr_eff == ADDR_W'(LED_ADDR));
  assign hit_sw  = (addr_eff == ADDR_W'(SW_ADDR));

  // RAM has no reset, so a commit must also be blocked while reset is held.
  assign ram_we = enter_done && (cmd_eff == MWRITE) && hit_ram && reset;

  ram_array #(
    .DATA_W    (DATA_W),
    .RAM_DEPTH (RAM_DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (addr_eff[RAM_AW-1:0]),
    .wdata (wdata_eff),
    .rdata (ram_rdata)
  );

  always_comb begin
    rd_mux = '0;
    if (hit_ram)      rd_mux = ram_rdata;
    else if (hit_led) rd_mux = DATA_W'(led);
    else if (hit_sw)  rd_mux = DATA_W'(sw_sync);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.read_data <= '0;
    end else if (enter_done) begin
      bus.read_data <= (cmd_eff == MREAD) ? rd_mux : '0;
    end
  end

  assign bus.mem_ready = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led <= 8'h00;
    end else if (enter_done && (cmd_eff == MWRITE) && hit_led) begin
      led <= wdata_eff[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_meta <= 8'h00;
      sw_sync <= 8'h00;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
    end
  end

`ifdef MEM_ERR_EN
  logic err_hit;

  // Only requests sampled in IDLE can raise the flag; addr_eff is the live address there.
  assign err_hit = (state == IDLE) &&
                   ((bus.mem_cmd == MILL) ||
                    (accept && (!(hit_ram || hit_led || hit_sw) ||
                                ((bus.mem_cmd == MWRITE) && hit_sw))));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       err <= 1'b0;
    else if (err_hit) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one instance with one wait state, one with none.
module tb_mem_responder;
  import mem_pkg::*;

`ifdef MEM_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sw = 8'hFF;
  logic [7:0] led1, led0;
  logic       err1, err0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] q1[$];
  logic [15:0] q0[$];
  logic [15:0] e1, e0;

  always #5 clk = ~clk;

  mem_responder_if #(.DATA_W(16), .ADDR_W(9)) b1 ();
  mem_responder_if #(.DATA_W(16), .ADDR_W(9)) b0 ();

  mem_responder #(.DATA_W(16), .ADDR_W(9), .RAM_DEPTH(256), .WAIT_STATES(1)) dut (
    .clk (clk), .reset (rst_n), .bus (b1), .sw (sw), .led (led1), .err (err1)
  );

  mem_responder #(.DATA_W(16), .ADDR_W(9), .RAM_DEPTH(256), .WAIT_STATES(0)) dut0 (
    .clk (clk), .reset (rst_n), .bus (b0), .sw (sw), .led (led0), .err (err0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: each mem_ready must match a pending expectation, in order.
  always @(negedge clk) begin
    if (b1.mem_ready) begin
      check("pend1", 32'(q1.size() > 0), 32'd1);
      if (q1.size() > 0) begin
        e1 = q1.pop_front();
        check("rdata1", 32'(b1.read_data), 32'(e1));
      end
    end
    if (b0.mem_ready) begin
      check("pend0", 32'(q0.size() > 0), 32'd1);
      if (q0.size() > 0) begin
        e0 = q0.pop_front();
        check("rdata0", 32'(b0.read_data), 32'(e0));
      end
    end
  end

  task automatic access(input bit sel, input logic [1:0] cmd, input logic [8:0] addr,
                        input logic [15:0] wd, input logic [15:0] exp, input int exp_lat);
    int  lat;
    bit  seen;
    @(negedge clk);
    if (sel) begin
      b0.mem_cmd = cmd; b0.mem_addr = addr; b0.write_data = wd; q0.push_back(exp);
    end else begin
      b1.mem_cmd = cmd; b1.mem_addr = addr; b1.write_data = wd; q1.push_back(exp);
    end
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      seen = sel ? b0.mem_ready : b1.mem_ready;
    end
    check(sel ? "latency0" : "latency1", 32'(lat), 32'(exp_lat));
    if (sel) b0.mem_cmd = MNONE;
    else     b1.mem_cmd = MNONE;
    @(negedge clk);
  endtask

  initial begin
    b1.mem_cmd = MNONE; b1.mem_addr = '0; b1.write_data = '0;
    b0.mem_cmd = MNONE; b0.mem_addr = '0; b0.write_data = '0;

    // 1: reset state, then idle bus
    repeat (3) begin
      @(negedge clk);
      check("rst_rdata", 32'(b1.read_data), 32'd0);
      check("rst_ready", 32'(b1.mem_ready), 32'd0);
      check("rst_led",   32'(led1), 32'd0);
      check("rst_err",   32'(err1), 32'd0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_ready", 32'(b1.mem_ready), 32'd0);
    end

    // 2: RAM write then read back
    access(0, MWRITE, 9'h003, 16'h0005, 16'h0000, 2);
    access(0, MREAD,  9'h003, 16'h0000, 16'h0005, 2);

    // 3: LED register
    access(0, MWRITE, 9'h100, 16'hABCD, 16'h0000, 2);
    check("led_cd", 32'(led1), 32'h00CD);
    access(0, MREAD,  9'h100, 16'h0000, 16'h00CD, 2);

    // 4: synchronised switches
    @(negedge clk);
    sw = 8'h5A;
    repeat (3) @(negedge clk);
    access(0, MREAD, 9'h140, 16'h0000, 16'h005A, 2);

    // 5: unmapped read and illegal command
    access(0, MREAD, 9'h1FF, 16'h0000, 16'h0000, 2);
    check("err_unmapped", 32'(err1), 32'(ERR_EN));
    @(negedge clk);
    b1.mem_cmd = MILL;
    repeat (3) begin
      @(negedge clk);
      check("ill_noready", 32'(b1.mem_ready), 32'd0);
    end
    b1.mem_cmd = MNONE;
    check("err_sticky", 32'(err1), 32'(ERR_EN));

    // 6: reset during WAIT discards the pending write
    access(0, MWRITE, 9'h010, 16'h1111, 16'h0000, 2);
    @(negedge clk);
    b1.mem_cmd = MWRITE; b1.mem_addr = 9'h010; b1.write_data = 16'h2222;
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("abort_ready_a", 32'(b1.mem_ready), 32'd0);
    @(negedge clk);
    check("abort_ready_b", 32'(b1.mem_ready), 32'd0);
    check("abort_led", 32'(led1), 32'd0);
    check("abort_err", 32'(err1), 32'd0);
    b1.mem_cmd = MNONE;
    @(negedge clk);
    rst_n = 1'b1;
    access(0, MREAD, 9'h010, 16'h0000, 16'h1111, 2);

    // Zero wait states: illegal command, then reset before the commit edge
    @(negedge clk);
    b0.mem_cmd = MILL;
    repeat (2) begin
      @(negedge clk);
      check("ill0_noready", 32'(b0.mem_ready), 32'd0);
    end
    b0.mem_cmd = MNONE;
    check("err0_ill", 32'(err0), 32'(ERR_EN));
    access(1, MWRITE, 9'h010, 16'h1111, 16'h0000, 1);
    access(1, MREAD,  9'h010, 16'h0000, 16'h1111, 1);
    @(negedge clk);
    b0.mem_cmd = MWRITE; b0.mem_addr = 9'h010; b0.write_data = 16'h2222;
    rst_n = 1'b0;
    @(negedge clk);
    check("abort0_ready", 32'(b0.mem_ready), 32'd0);
    check("abort0_err", 32'(err0), 32'd0);
    b0.mem_cmd = MNONE;
    @(negedge clk);
    rst_n = 1'b1;
    access(1, MREAD, 9'h010, 16'h0000, 16'h1111, 1);

    repeat (3) @(negedge clk);
    check("q1_drained", 32'(q1.size()), 32'd0);
    check("q0_drained", 32'(q0.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
